// File: rtl/mac_feeder.sv
// Purpose: pairs each SpMV nonzero with x[col] from vector memory and pushes them to the mac in order.
// Latency: vec_req one cycle after accept; wr at the earliest one edge after the x[col] response lands.
// Backpressure: nz_ready drops when FIFO_DEPTH nonzeros are in flight or the matrix is closing; stall holds pushes.
module mac_feeder #(
    parameter int INTERMEDIATOR_DEPTH      = 8,
    parameter int LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH - 1),
    parameter int COL_WIDTH                = 32,
    parameter int FIFO_DEPTH               = 16,
    parameter int EOF_DELAY                = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                nz_valid,
    output logic                                nz_ready,
    input  logic                                nz_last,
    input  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] nz_row,
    input  logic [COL_WIDTH-1:0]                nz_col,
    input  logic [63:0]                         nz_val,
    output logic                                vec_req,
    output logic [COL_WIDTH-1:0]                vec_addr,
    input  logic                                vec_rsp_valid,
    input  logic [63:0]                         vec_rsp_data,
    output logic                                wr,
    output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
    output logic [63:0]                         v0,
    output logic [63:0]                         v1,
    input  logic                                stall,
    output logic                                eof,
    output logic                                busy,
    output logic                                err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(EOF_DELAY + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WAIT, S_EOF} state_t;

    state_t                state, state_nxt;
    logic [DW-1:0]         delay, delay_nxt;

    // Entry storage: row/value written on accept, x[col] written by the fill pointer.
    logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row_mem [FIFO_DEPTH];
    logic [63:0]           val_mem [FIFO_DEPTH];
    logic [63:0]           x_mem   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] filled;

    logic [PW-1:0]         head, tail, fill;
    logic [CW-1:0]         count;        // accepted, not yet pushed
    logic [CW-1:0]         outstanding;  // requests issued, not yet answered

    logic accept, do_push, rsp_ok;

    assign accept   = nz_valid && nz_ready;
    assign do_push  = !stall && (count != '0) && filled[head];
    // Only answers to issued requests are accepted; anything else is dropped.
    assign rsp_ok   = vec_rsp_valid && (outstanding != '0);

    assign nz_ready = !rst && (count != FULL) && (state == S_IDLE || state == S_RUN);
    assign eof      = (state == S_EOF);
    assign busy     = (state != S_IDLE) || (count != '0);

    // Payload storage needs no reset; validity lives in the filled bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_mem[tail] <= nz_row;
            val_mem[tail] <= nz_val;
        end
        if (rsp_ok) begin
            x_mem[fill] <= vec_rsp_data;
        end
    end

    // Pointers, occupancy, request issue, push register and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            outstanding <= '0;
            filled      <= '0;
            vec_req     <= 1'b0;
            vec_addr    <= '0;
            wr          <= 1'b0;
            row         <= '0;
            v0          <= '0;
            v1          <= '0;
            err         <= 1'b0;
        end else begin
            vec_req <= accept;
            if (accept) begin
                vec_addr     <= nz_col;
                filled[tail] <= 1'b0;
                tail         <= tail + 1'b1;
            end
            if (rsp_ok) begin
                filled[fill] <= 1'b1;
                fill         <= fill + 1'b1;
            end
            if (vec_rsp_valid && (outstanding == '0)) begin
                err <= 1'b1;
            end
            wr <= do_push;
            if (do_push) begin
                row          <= row_mem[head];
                v0           <= val_mem[head];
                v1           <= x_mem[head];
                filled[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            case ({accept, do_push})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({vec_req, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    // Matrix-level state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            delay <= '0;
        end else begin
            state <= state_nxt;
            delay <= delay_nxt;
        end
    end

    // Next state: close the matrix on the last nonzero, drain, idle EOF_DELAY cycles, pulse eof.
    always_comb begin
        state_nxt = state;
        delay_nxt = delay;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = nz_last ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (accept && nz_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // count reaches zero in the cycle the final wr is presented.
                if (count == '0) begin
                    state_nxt = S_WAIT;
                    delay_nxt = '0;
                end
            end
            S_WAIT: begin
                if (delay == DW'(EOF_DELAY - 1)) state_nxt = S_EOF;
                else                             delay_nxt = delay + 1'b1;
            end
            S_EOF: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: vector table of single-nonzero matrices, streaming,
// stall, random latency, unsolicited response and mid-stream reset sequences.
module tb_mac_feeder;
    localparam int FD = 16;
    localparam int ED = 16;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          nz_valid = 1'b0, nz_last = 1'b0;
    logic          nz_ready;
    logic [LW-1:0] nz_row = '0;
    logic [31:0]   nz_col = '0;
    logic [63:0]   nz_val = '0;
    logic          vec_req;
    logic [31:0]   vec_addr;
    logic          vec_rsp_valid = 1'b0;
    logic [63:0]   vec_rsp_data = '0;
    logic          wr;
    logic [LW-1:0] row;
    logic [63:0]   v0, v1;
    logic          stall = 1'b0;
    logic          eof, busy, err;

    mac_feeder #(
        .INTERMEDIATOR_DEPTH(8), .COL_WIDTH(32), .FIFO_DEPTH(FD), .EOF_DELAY(ED)
    ) dut (
        .clk(clk), .rst(rst),
        .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_last(nz_last),
        .nz_row(nz_row), .nz_col(nz_col), .nz_val(nz_val),
        .vec_req(vec_req), .vec_addr(vec_addr),
        .vec_rsp_valid(vec_rsp_valid), .vec_rsp_data(vec_rsp_data),
        .wr(wr), .row(row), .v0(v0), .v1(v1), .stall(stall),
        .eof(eof), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: every accepted nonzero must come out once, in order, as {row, val, x[col]}.
    typedef struct packed { logic [LW-1:0] e_row; logic [63:0] e_v0; logic [63:0] e_v1; } exp_t;
    typedef struct packed { logic [31:0] addr; int due; } req_t;
    exp_t expq[$];
    req_t pend[$];

    int   lat_min = 1, lat_max = 1, stall_mode = 0;
    bit   inject = 1'b0, saw_full = 1'b0;
    int   acc_cnt = 0, push_cnt = 0, max_inflight = 0;
    int   wr_total = 0, eof_total = 0, last_wr_cyc = 0;
    logic stall_q = 1'b0;
    logic [LW-1:0] last_row = '0;
    logic [63:0]   last_v0 = '0, last_v1 = '0;

    function automatic logic [63:0] vec_mem(input logic [31:0] c);
        if (c == 32'd5) return 64'h4000_0000_0000_0000;  // 2.0
        return {c ^ 32'hA5A5_0000, ~c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Vector memory: in-order responses, per-request latency drawn from [lat_min, lat_max].
    always begin
        req_t r;
        @(posedge clk); #1;
        if (rst) begin
            pend.delete();
            vec_rsp_valid = 1'b0;
        end else begin
            if (vec_req) begin
                r.addr = vec_addr;
                r.due  = cyc + int'($urandom_range(lat_max, lat_min));
                pend.push_back(r);
            end
            if (inject) begin
                vec_rsp_valid = 1'b1;
                vec_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
                inject        = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                vec_rsp_valid = 1'b1;
                vec_rsp_data  = vec_mem(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                vec_rsp_valid = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk); #2;
        case (stall_mode)
            0:       stall = 1'b0;
            1:       stall = 1'b1;
            default: stall = ($urandom_range(3, 0) == 0);
        endcase
    end

    always @(posedge clk) stall_q <= stall;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int   infl;
        if (!rst) begin
            if (wr) begin
                push_cnt++;
                wr_total++;
                last_wr_cyc = cyc;
                last_row = row; last_v0 = v0; last_v1 = v1;
                check("wr_during_stall", 64'(stall_q), 64'(0));
                if (expq.size() == 0) begin
                    check("wr_unexpected", 64'(1), 64'(0));
                end else begin
                    e = expq.pop_front();
                    check("wr_row", 64'(row), 64'(e.e_row));
                    check("wr_v0", v0, e.e_v0);
                    check("wr_v1", v1, e.e_v1);
                end
            end
            infl = acc_cnt - push_cnt;
            if (infl > max_inflight) max_inflight = infl;
            if (infl == FD) begin
                saw_full = 1'b1;
                check("full_nz_ready", 64'(nz_ready), 64'(0));
            end
            if (eof) begin
                eof_total++;
                check("eof_gap", 64'(cyc - last_wr_cyc - 1), 64'(ED));
                check("eof_drained", 64'(expq.size()), 64'(0));
            end
            if (nz_valid && nz_ready) begin
                e.e_row = nz_row; e.e_v0 = nz_val; e.e_v1 = vec_mem(nz_col);
                expq.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic send_nz(input logic [LW-1:0] r, input logic [31:0] c, input logic [63:0] v, input logic last);
        bit ok;
        ok = 1'b0;
        nz_valid = 1'b1; nz_row = r; nz_col = c; nz_val = v; nz_last = last;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (nz_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 64'(nz_ready), 64'(1));
        @(posedge clk); #1;
        nz_valid = 1'b0; nz_last = 1'b0;
    endtask

    task automatic wait_eof(input string name, input int budget);
        int  e0;
        bit  ok;
        e0 = eof_total; ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            if (eof_total != e0) begin ok = 1'b1; break; end
        end
        if (!ok) check(name, 64'(eof_total - e0), 64'(1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [LW-1:0] n_row; logic [31:0] n_col; logic [63:0] n_val; int lat;
        logic [LW-1:0] x_row; logic [63:0] x_v0; logic [63:0] x_v1;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        int w0, e0;
        tbl[0] = '{3'd2, 32'd5,          64'h3FF8_0000_0000_0000, 3,  3'd2, 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000};
        tbl[1] = '{3'd0, 32'd0,          64'h0000_0000_0000_0000, 1,  3'd0, 64'h0000_0000_0000_0000, 64'hA5A5_0000_FFFF_FFFF};
        tbl[2] = '{3'd7, 32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 40, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5A5A_FFFF_0000_0000};
        tbl[3] = '{3'd5, 32'd7,          64'hC009_21FB_5444_2D18, 2,  3'd5, 64'hC009_21FB_5444_2D18, 64'hA5A5_0007_FFFF_FFF8};

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_nz_ready", 64'(nz_ready), 64'(0));
        check("rst_vec_req", 64'(vec_req), 64'(0));
        check("rst_wr", 64'(wr), 64'(0));
        check("rst_eof", 64'(eof), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_datapath", 64'(row) | v0 | v1, 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_nz_ready", 64'(nz_ready), 64'(1));

        // Single-nonzero matrices from the table
        for (int i = 0; i < 4; i++) begin
            w0 = wr_total; e0 = eof_total;
            lat_min = tbl[i].lat; lat_max = tbl[i].lat;
            send_nz(tbl[i].n_row, tbl[i].n_col, tbl[i].n_val, 1'b1);
            check("tbl_vec_req", 64'(vec_req), 64'(1));
            check("tbl_vec_addr", 64'(vec_addr), 64'(tbl[i].n_col));
            @(posedge clk); #1;
            check("tbl_vec_req_pulse", 64'(vec_req), 64'(0));
            wait_eof("tbl_eof_timeout", 300);
            check("tbl_wr_count", 64'(wr_total - w0), 64'(1));
            check("tbl_eof_count", 64'(eof_total - e0), 64'(1));
            check("tbl_row", 64'(last_row), 64'(tbl[i].x_row));
            check("tbl_v0", last_v0, tbl[i].x_v0);
            check("tbl_v1", last_v1, tbl[i].x_v1);
            check("tbl_err", 64'(err), 64'(0));
            check("tbl_busy", 64'(busy), 64'(0));
        end

        // 25 back-to-back, latency 1
        w0 = wr_total; e0 = eof_total;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 25; i++)
            send_nz(LW'(i % 8), 32'(i * 3), {$urandom, $urandom}, i == 24);
        wait_eof("b2b_eof_timeout", 400);
        check("b2b_wr_count", 64'(wr_total - w0), 64'(25));
        check("b2b_eof_count", 64'(eof_total - e0), 64'(1));

        // Stall 20 cycles mid-stream; FIFO must fill
        w0 = wr_total; e0 = eof_total; saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send_nz(LW'($urandom_range(7, 0)), $urandom, {$urandom, $urandom}, i == 29);
            end
            begin
                repeat (6) @(posedge clk);
                #1 stall_mode = 1;
                repeat (20) @(posedge clk);
                #1 stall_mode = 0;
            end
        join
        wait_eof("stall_eof_timeout", 500);
        check("stall_wr_count", 64'(wr_total - w0), 64'(30));
        check("stall_eof_count", 64'(eof_total - e0), 64'(1));
        check("stall_saw_full", 64'(saw_full), 64'(1));

        // Random latency 1..40, random stall, random gaps
        w0 = wr_total; e0 = eof_total; max_inflight = 0;
        lat_min = 1; lat_max = 40; stall_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send_nz(LW'($urandom_range(7, 0)), $urandom_range(64, 0), {$urandom, $urandom}, i == 59);
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
        wait_eof("rand_eof_timeout", 6000);
        stall_mode = 0;
        check("rand_wr_count", 64'(wr_total - w0), 64'(60));
        check("rand_eof_count", 64'(eof_total - e0), 64'(1));
        check("rand_max_inflight_le_depth", 64'(max_inflight <= FD), 64'(1));

        // Unsolicited response sets sticky err; stream unaffected
        repeat (3) @(posedge clk); #1;
        inject = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("unsolicited_err", 64'(err), 64'(1));
        w0 = wr_total; e0 = eof_total;
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 3; i++)
            send_nz(LW'(i + 1), 32'(i + 4), {$urandom, $urandom}, i == 2);
        wait_eof("err_eof_timeout", 300);
        check("err_sticky", 64'(err), 64'(1));
        check("err_wr_count", 64'(wr_total - w0), 64'(3));

        // Reset with 8 in flight, then a fresh 3-nonzero matrix
        stall_mode = 1; lat_min = 2; lat_max = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++)
            send_nz(LW'(i), 32'(i + 10), {$urandom, $urandom}, 1'b0);
        repeat (15) @(posedge clk); #1;
        check("pre_rst_busy", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        check("mid_rst_nz_ready", 64'(nz_ready), 64'(0));
        check("mid_rst_wr_req_eof", 64'({wr, vec_req, eof}), 64'(0));
        check("mid_rst_datapath", 64'(row) | v0 | v1, 64'(0));
        expq.delete(); acc_cnt = 0; push_cnt = 0; stall_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst2_nz_ready", 64'(nz_ready), 64'(1));
        w0 = wr_total; e0 = eof_total;
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++)
            send_nz(LW'(6 - i), 32'(i + 20), {$urandom, $urandom}, i == 2);
        wait_eof("rst_eof_timeout", 300);
        check("rst_wr_count", 64'(wr_total - w0), 64'(3));
        check("rst_eof_count", 64'(eof_total - e0), 64'(1));
        check("rst_err_clear", 64'(err), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
